// File: rtl/traffic_light_pkg.sv
// Shared light-code, phase and error encodings for the traffic-light controller and its monitor.
package traffic_light_pkg;

    localparam logic [2:0] L_OFF    = 3'd0;
    localparam logic [2:0] L_RED    = 3'd1;
    localparam logic [2:0] L_GREEN  = 3'd2;
    localparam logic [2:0] L_YELLOW = 3'd3;

    // Phase encoding matches the light code for red/green/yellow.
    typedef enum logic [1:0] {
        PhSync   = 2'd0,
        PhRed    = 2'd1,
        PhGreen  = 2'd2,
        PhYellow = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        E_NONE  = 3'd0,
        E_SEQ   = 3'd1,
        E_SHORT = 3'd2,
        E_LONG  = 3'd3,
        E_CODE  = 3'd4
    } err_e;

    function automatic logic [2:0] next_light(input phase_e ph);
        case (ph)
            PhRed:    return L_GREEN;
            PhGreen:  return L_YELLOW;
            PhYellow: return L_RED;
            default:  return L_RED;
        endcase
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter: loads 1 when a new code arrives, otherwise counts up and sticks at max.
module dwell_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light code bus: tracks the phase sequence, times each
// phase, and reports illegal codes, illegal transitions and out-of-range dwell times.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned MIN_DWELL = 4,
    parameter int unsigned MAX_DWELL = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_in,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             err_pulse,
    output logic [2:0]       err_code,
    output logic             err_sticky,
    output logic [15:0]      cycles
);

    localparam logic [CNT_W-1:0] MinD = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] MaxD = CNT_W'(MAX_DWELL);

    logic [2:0]  light_q;
    phase_e      phase_q, phase_d;
    logic        err_pulse_q, err_pulse_d;
    err_e        err_code_q, err_code_d;
    logic        err_sticky_q, err_sticky_d;
    logic [15:0] cycles_q, cycles_d;
    logic        change;
    logic        cyc_inc;
    err_e        err;

    assign change = (light_in != light_q);

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load_i  (change),
        .count_o (dwell)
    );

    always_comb begin
        phase_d = phase_q;
        err     = E_NONE;
        cyc_inc = 1'b0;
        case (phase_q)
            PhSync: begin
                if (light_in[2] && change) begin
                    err = E_CODE;
                end else if (light_in == L_RED) begin
                    phase_d = PhRed;
                end
            end
            default: begin
                if (change) begin
                    if (light_in[2]) begin
                        err     = E_CODE;
                        phase_d = PhSync;
                    end else if (light_in == next_light(phase_q)) begin
                        phase_d = phase_e'(light_in[1:0]);
                        cyc_inc = (phase_q == PhYellow);
                        if (dwell < MinD) begin
                            err = E_SHORT;
                        end
                    end else if (light_in == L_OFF) begin
                        err     = E_SEQ;
                        phase_d = PhSync;
                    end else begin
                        err     = E_SEQ;
                        phase_d = phase_e'(light_in[1:0]);
                    end
                end else if (dwell == MaxD) begin
                    // Counter is about to show MAX_DWELL+1; this value occurs once per phase.
                    err = E_LONG;
                end
            end
        endcase
    end

    always_comb begin
        err_pulse_d  = (err != E_NONE);
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
        if (err != E_NONE) begin
            err_sticky_d = 1'b1;
            if (!err_sticky_q || clr_err) begin
                err_code_d = err;
            end
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
            err_code_d   = E_NONE;
        end
        cycles_d = cycles_q;
        if (cyc_inc && cycles_q != 16'hFFFF) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            light_q      <= L_OFF;
            phase_q      <= PhSync;
            err_pulse_q  <= 1'b0;
            err_code_q   <= E_NONE;
            err_sticky_q <= 1'b0;
            cycles_q     <= '0;
        end else begin
            light_q      <= light_in;
            phase_q      <= phase_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
            cycles_q     <= cycles_d;
        end
    end

    assign phase      = phase_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  light_in = 3'd0;
    logic        clr_err = 1'b0;
    logic [1:0]  phase;
    logic [7:0]  dwell;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic [15:0] cycles;

    int checks = 0;
    int passed = 0;

    traffic_light_monitor #(
        .MIN_DWELL (4),
        .MAX_DWELL (16),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_in   (light_in),
        .clr_err    (clr_err),
        .phase      (phase),
        .dwell      (dwell),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] code, input int n);
        repeat (n) begin
            light_in = code;
            step();
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        clr_err  = 1'b0;
        light_in = 3'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({phase, dwell, err_pulse, err_code, err_sticky, cycles} !== 31'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {phase, dwell, err_pulse, err_code, err_sticky, cycles});
        else passed++;
    endtask

    task automatic test_sequence();
        drive(3'd1, 1);
        checks++; if (phase !== 2'd1 || dwell !== 8'd1)
            $display("FAIL seq_enter_red: got phase %0d dwell %0d expected 1 1", phase, dwell);
        else passed++;
        drive(3'd1, 7);
        checks++; if (dwell !== 8'd8)
            $display("FAIL seq_red_dwell: got %0d expected 8", dwell);
        else passed++;
        drive(3'd2, 1);
        checks++; if (phase !== 2'd2 || dwell !== 8'd1 || err_pulse !== 1'b0)
            $display("FAIL seq_green: got phase %0d dwell %0d pulse %0d expected 2 1 0",
                     phase, dwell, err_pulse);
        else passed++;
        drive(3'd2, 7);
        drive(3'd3, 8);
        checks++; if (phase !== 2'd3 || cycles !== 16'd0)
            $display("FAIL seq_yellow: got phase %0d cycles %0d expected 3 0", phase, cycles);
        else passed++;
        drive(3'd1, 1);
        checks++; if (phase !== 2'd1 || cycles !== 16'd1)
            $display("FAIL seq_cycle_done: got phase %0d cycles %0d expected 1 1", phase, cycles);
        else passed++;
        checks++; if (err_sticky !== 1'b0 || err_code !== 3'd0 || err_pulse !== 1'b0)
            $display("FAIL seq_no_errors: got sticky %0d code %0d pulse %0d expected 0 0 0",
                     err_sticky, err_code, err_pulse);
        else passed++;
    endtask

    task automatic test_bad_transition();
        drive(3'd1, 7);
        drive(3'd3, 1);
        checks++; if (err_pulse !== 1'b1 || err_code !== 3'd1 || phase !== 2'd3 || err_sticky !== 1'b1)
            $display("FAIL bad_trans: got pulse %0d code %0d phase %0d sticky %0d expected 1 1 3 1",
                     err_pulse, err_code, phase, err_sticky);
        else passed++;
        drive(3'd3, 1);
        checks++; if (err_pulse !== 1'b0 || err_sticky !== 1'b1)
            $display("FAIL bad_trans_pulse_once: got pulse %0d sticky %0d expected 0 1",
                     err_pulse, err_sticky);
        else passed++;
    endtask

    task automatic test_short_dwell();
        do_reset();
        checks++; if (cycles !== 16'd0 || err_sticky !== 1'b0)
            $display("FAIL short_reset_clears: got cycles %0d sticky %0d expected 0 0",
                     cycles, err_sticky);
        else passed++;
        drive(3'd1, 8);
        drive(3'd2, 2);
        drive(3'd3, 1);
        checks++; if (err_pulse !== 1'b1 || err_code !== 3'd2 || phase !== 2'd3)
            $display("FAIL short_dwell: got pulse %0d code %0d phase %0d expected 1 2 3",
                     err_pulse, err_code, phase);
        else passed++;
    endtask

    task automatic test_long_dwell();
        int pulses = 0;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(3'd1, 1);
            if (err_pulse === 1'b1) pulses++;
            checks++; if (err_pulse !== (k == 17))
                $display("FAIL long_pulse_at_%0d: got %0d expected %0d", k, err_pulse, (k == 17));
            else passed++;
        end
        checks++; if (pulses !== 1 || err_code !== 3'd3 || dwell !== 8'd20)
            $display("FAIL long_summary: got pulses %0d code %0d dwell %0d expected 1 3 20",
                     pulses, err_code, dwell);
        else passed++;
    endtask

    task automatic test_illegal_code();
        do_reset();
        drive(3'd1, 8);
        drive(3'd2, 3);
        drive(3'd5, 1);
        checks++; if (err_pulse !== 1'b1 || err_code !== 3'd4 || phase !== 2'd0)
            $display("FAIL illegal_code: got pulse %0d code %0d phase %0d expected 1 4 0",
                     err_pulse, err_code, phase);
        else passed++;
        drive(3'd5, 1);
        checks++; if (err_pulse !== 1'b0)
            $display("FAIL illegal_held: got pulse %0d expected 0", err_pulse);
        else passed++;
        drive(3'd1, 1);
        checks++; if (phase !== 2'd1 || err_pulse !== 1'b0 || err_code !== 3'd4)
            $display("FAIL resync_red: got phase %0d pulse %0d code %0d expected 1 0 4",
                     phase, err_pulse, err_code);
        else passed++;
    endtask

    task automatic test_clr_collision();
        do_reset();
        drive(3'd1, 8);
        drive(3'd2, 2);
        drive(3'd3, 2);
        checks++; if (err_code !== 3'd2 || err_sticky !== 1'b1)
            $display("FAIL collide_setup: got code %0d sticky %0d expected 2 1", err_code, err_sticky);
        else passed++;
        clr_err = 1'b1;
        drive(3'd2, 1);
        clr_err = 1'b0;
        checks++; if (err_pulse !== 1'b1 || err_sticky !== 1'b1 || err_code !== 3'd1 || phase !== 2'd2)
            $display("FAIL clr_collision: got pulse %0d sticky %0d code %0d phase %0d expected 1 1 1 2",
                     err_pulse, err_sticky, err_code, phase);
        else passed++;
        clr_err = 1'b1;
        drive(3'd2, 1);
        clr_err = 1'b0;
        checks++; if (err_sticky !== 1'b0 || err_code !== 3'd0 || err_pulse !== 1'b0)
            $display("FAIL clr_alone: got sticky %0d code %0d pulse %0d expected 0 0 0",
                     err_sticky, err_code, err_pulse);
        else passed++;
    endtask

    task automatic test_reset_mid_yellow();
        drive(3'd2, 6);
        drive(3'd3, 3);
        checks++; if (phase !== 2'd3 || dwell !== 8'd3)
            $display("FAIL pre_reset_yellow: got phase %0d dwell %0d expected 3 3", phase, dwell);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({phase, dwell, err_pulse, err_code, err_sticky, cycles} !== 31'd0)
            $display("FAIL reset_mid_yellow: got %h expected 0",
                     {phase, dwell, err_pulse, err_code, err_sticky, cycles});
        else passed++;
    endtask

    task automatic test_sync_idle();
        do_reset();
        drive(3'd0, 300);
        checks++; if (dwell !== 8'hFF || err_sticky !== 1'b0 || phase !== 2'd0)
            $display("FAIL sync_idle: got dwell %0d sticky %0d phase %0d expected 255 0 0",
                     dwell, err_sticky, phase);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_bad_transition();
        test_short_dwell();
        test_long_dwell();
        test_illegal_code();
        test_clr_collision();
        test_reset_mid_yellow();
        test_sync_idle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the 3-bit traffic-light code bus driven by the intersection controller.
- Samples the light code every cycle and tracks the phase sequence RED→GREEN→YELLOW→RED.
- Measures how long each phase dwells, flags illegal codes, illegal transitions and out-of-range dwell times, and counts completed light cycles.
- Sits beside the controller on the same clock, feeding status/debug registers and a safety interlock.

## Interface
- MIN_DWELL, 4: minimum legal cycles a RED/GREEN/YELLOW code must be held.
- MAX_DWELL, 16: maximum legal cycles a RED/GREEN/YELLOW code may be held; must exceed MIN_DWELL.
- CNT_W, 8: dwell counter width; must satisfy 2^CNT_W − 1 ≥ MAX_DWELL + 1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- light_in  in  3  controller light code: 0 off, 1 red, 2 green, 3 yellow, 4–7 illegal.
- clr_err  in  1  clears err_sticky and err_code.
- phase  out  2  tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW.
- dwell  out  CNT_W  cycles the current code has been held, saturating.
- err_pulse  out  1  one-cycle pulse on any detected error.
- err_code  out  3  first error since clear: 0 none, 1 bad transition, 2 short dwell, 3 long dwell, 4 illegal code.
- err_sticky  out  1  set on first error, held until clr_err or rst.
- cycles  out  16  completed YELLOW→RED transitions, saturating at 16'hFFFF.

## Operation
- light_in is registered into light_q each cycle; a change is `light_in != light_q`.
- dwell:
  - loads 1 on a change, otherwise increments;
  - saturates at 2^CNT_W − 1.
- FSM states: SYNC, RED, GREEN, YELLOW.
- SYNC:
  - codes 0–3 other than red are ignored;
  - on red, go to RED with no dwell check;
  - code 4–7 raises error 4 and stays in SYNC.
- RED/GREEN/YELLOW, on a change:
  - Legal next code (RED→GREEN, GREEN→YELLOW, YELLOW→RED): advance. If the completed dwell < MIN_DWELL, raise error 2 but still advance.
  - Other code 1–3: raise error 1 and jump to the state matching the new code (resync).
  - Code 0: raise error 1 and go to SYNC.
  - Code 4–7: raise error 4 and go to SYNC.
- Long dwell: when dwell reaches MAX_DWELL+1 while in RED/GREEN/YELLOW, raise error 3 exactly once per phase occurrence.
- cycles increments on each legal YELLOW→RED transition, including one that also raises error 2.
- Error priority when several occur in one cycle: 4 > 1 > 2 > 3.
- err_code latches only while err_sticky is 0.
- clr_err and a new error in the same cycle: the new error wins, so err_sticky=1 and err_code takes the new code.

## Timing
- Reset values: phase=0, dwell=0, err_pulse=0, err_code=0, err_sticky=0, cycles=0, light_q=0.
- All outputs are registered.
- A code change on light_in at edge N shows up in phase, dwell=1, err_pulse and cycles after edge N+1 (latency 1).
- err_pulse is high for exactly one cycle per error event.
- rst mid-phase: all state clears on the next edge. The first red after reset is not dwell-checked.
- Steady code 0 in SYNC: no errors, dwell keeps counting to saturation.

## Structure
- Shared package traffic_light_pkg holds:
  - light code constants L_OFF=0, L_RED=1, L_GREEN=2, L_YELLOW=3;
  - the phase state encoding;
  - the error code constants E_NONE, E_SEQ, E_SHORT, E_LONG, E_CODE.
- The controller also imports the light constants from this package.
- One sub-module, dwell_counter: a CNT_W saturating counter with a load-to-1 input. The dwell-check comparators stay in the top module.

## Test plan
- Reset, then light_in = 1×8, 2×8, 3×8, 1 → phase 1→2→3→1, no errors, cycles=1 one cycle after the final red.
- In RED after 8 cycles, drive 3 → err_pulse once, err_code=1, phase=3, err_sticky=1.
- GREEN held 2 cycles, then 3 → err_code=2, phase still advances to 3.
- RED held 20 cycles → single err_pulse when dwell=17, err_code=3.
- light_in=5 in GREEN → err_code=4, phase=0; then red → phase=1 with no short-dwell error.
- With err_sticky=1, assert clr_err in the same cycle as a new illegal transition → err_sticky stays 1, err_code=1. Also apply rst mid-YELLOW → all outputs return to reset values after the next edge.
